// File: rtl/systolic_feeder_if.sv
// Operand-load and feed bus between a controller and the systolic feeder.
// The controller drives the write/start side; the feeder drives the skewed operand streams.
interface systolic_feeder_if #(
    parameter int WIDTH = 8,
    parameter int N     = 2
);
    localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;

    logic                 wr_en;
    logic                 wr_sel;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 start;
    logic [N*WIDTH-1:0]   a_feed;
    logic [N*WIDTH-1:0]   b_feed;
    logic                 pe_clear;
    logic                 busy;
    logic                 done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  a_feed, b_feed, pe_clear, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output a_feed, b_feed, pe_clear, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers two NxN operand matrices and streams them, diagonally skewed, into the
// left column and top row of an NxN output-stationary systolic PE array.
module systolic_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);
    localparam int NN       = N * N;
    localparam int FEED_LEN = 3 * N - 2;
    localparam int CW       = $clog2(3 * N);
    localparam int AW       = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_t;
    logic [CW-1:0]      w_t_nxt;

    logic [WIDTH-1:0]   r_buf_a [NN];
    logic [WIDTH-1:0]   r_buf_b [NN];

    logic [N*WIDTH-1:0] r_a_feed;
    logic [N*WIDTH-1:0] r_b_feed;
    logic               r_pe_clear;
    logic               r_busy;
    logic               r_done;
    logic [N*WIDTH-1:0] w_a_feed_nxt;
    logic [N*WIDTH-1:0] w_b_feed_nxt;
    logic               w_pe_clear_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Buffers are frozen while a run is streaming so the feed never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) begin
                r_buf_a[k] <= '0;
                r_buf_b[k] <= '0;
            end
        end else if (bus.wr_en && !r_busy) begin
            for (int k = 0; k < NN; k++) begin
                if (bus.wr_addr == AW'(k)) begin
                    if (bus.wr_sel) r_buf_b[k] <= bus.wr_data;
                    else            r_buf_a[k] <= bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_a_feed   <= '0;
            r_b_feed   <= '0;
            r_pe_clear <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_a_feed   <= w_a_feed_nxt;
            r_b_feed   <= w_b_feed_nxt;
            r_pe_clear <= w_pe_clear_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Outputs are decoded from the next state so they appear registered in that state.
    always_comb begin
        w_state_nxt    = r_state;
        w_t_nxt        = r_t;
        w_a_feed_nxt   = '0;
        w_b_feed_nxt   = '0;
        w_pe_clear_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nxt = S_FEED;
                w_t_nxt     = '0;
            end
            S_FEED: begin
                if (r_t == CW'(FEED_LEN - 1)) begin
                    w_state_nxt = S_DONE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase

        w_pe_clear_nxt = (w_state_nxt == S_CLEAR);
        w_busy_nxt     = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FEED);
        w_done_nxt     = (w_state_nxt == S_DONE);

        // Row i carries A[i][k] and column i carries B[k][i] on diagonal t = i + k.
        if (w_state_nxt == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(w_t_nxt) == i + k) begin
                        w_a_feed_nxt[i*WIDTH +: WIDTH] = r_buf_a[i*N + k];
                        w_b_feed_nxt[i*WIDTH +: WIDTH] = r_buf_b[k*N + i];
                    end
                end
            end
        end
    end

    assign bus.a_feed   = r_a_feed;
    assign bus.b_feed   = r_b_feed;
    assign bus.pe_clear = r_pe_clear;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: N=2 and N=4 instances, each feeding a behavioural PE array.
module tb_systolic_feeder;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        clr;
        logic        bsy;
        logic        dn;
    } rec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   matA [8][8];
    int   matB [8][8];
    rec_t tbl33 [6];
    rec_t sb [$];

    systolic_feeder_if #(.WIDTH(8), .N(2)) if2 ();
    systolic_feeder_if #(.WIDTH(8), .N(4)) if4 ();

    systolic_feeder #(.WIDTH(8), .N(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    systolic_feeder #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-stationary PE arrays: a moves right, b moves down, one register per PE.
    logic [15:0] acc2 [2][2];
    logic [7:0]  pa2  [2][2];
    logic [7:0]  pb2  [2][2];
    logic [15:0] acc4 [4][4];
    logic [7:0]  pa4  [4][4];
    logic [7:0]  pb4  [4][4];

    always @(posedge clk) begin : pe_arr2
        logic [7:0] ai, bi;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                ai = (j == 0) ? if2.a_feed[i*8 +: 8] : pa2[i][(j == 0) ? 0 : j - 1];
                bi = (i == 0) ? if2.b_feed[j*8 +: 8] : pb2[(i == 0) ? 0 : i - 1][j];
                if (if2.pe_clear) begin
                    acc2[i][j] <= '0; pa2[i][j] <= '0; pb2[i][j] <= '0;
                end else begin
                    acc2[i][j] <= acc2[i][j] + 16'(ai) * 16'(bi);
                    pa2[i][j]  <= ai;
                    pb2[i][j]  <= bi;
                end
            end
        end
    end

    always @(posedge clk) begin : pe_arr4
        logic [7:0] ai, bi;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ai = (j == 0) ? if4.a_feed[i*8 +: 8] : pa4[i][(j == 0) ? 0 : j - 1];
                bi = (i == 0) ? if4.b_feed[j*8 +: 8] : pb4[(i == 0) ? 0 : i - 1][j];
                if (if4.pe_clear) begin
                    acc4[i][j] <= '0; pa4[i][j] <= '0; pb4[i][j] <= '0;
                end else begin
                    acc4[i][j] <= acc4[i][j] + 16'(ai) * 16'(bi);
                    pa4[i][j]  <= ai;
                    pb4[i][j]  <= bi;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sample(input int n, output rec_t r);
        r = '{default: '0};
        if (n == 2) begin
            r.a[15:0] = if2.a_feed; r.b[15:0] = if2.b_feed;
            r.clr = if2.pe_clear; r.bsy = if2.busy; r.dn = if2.done;
        end else begin
            r.a[31:0] = if4.a_feed; r.b[31:0] = if4.b_feed;
            r.clr = if4.pe_clear; r.bsy = if4.busy; r.dn = if4.done;
        end
    endtask

    task automatic cmp_rec(input int n, input rec_t e, input string tag);
        rec_t r;
        sample(n, r);
        chk({tag, "_a_feed"},   r.a,   e.a);
        chk({tag, "_b_feed"},   r.b,   e.b);
        chk({tag, "_pe_clear"}, 64'(r.clr), 64'(e.clr));
        chk({tag, "_busy"},     64'(r.bsy), 64'(e.bsy));
        chk({tag, "_done"},     64'(r.dn),  64'(e.dn));
    endtask

    // Expected record for observed cycle c of a run: 0 = CLEAR, 1..3n-2 = FEED, 3n-1 = DONE.
    function automatic rec_t exp_rec(input int n, input int c);
        rec_t r;
        int t;
        r = '{default: '0};
        if (c == 0) begin
            r.clr = 1'b1; r.bsy = 1'b1;
        end else if (c <= 3*n - 2) begin
            r.bsy = 1'b1;
            t = c - 1;
            for (int i = 0; i < n; i++) begin
                if (t - i >= 0 && t - i < n) begin
                    r.a[i*8 +: 8] = 8'(matA[i][t-i]);
                    r.b[i*8 +: 8] = 8'(matB[t-i][i]);
                end
            end
        end else begin
            r.dn = 1'b1;
        end
        return r;
    endfunction

    function automatic logic cur_done(input int n);
        return (n == 2) ? if2.done : if4.done;
    endfunction

    function automatic logic [15:0] get_acc(input int n, input int i, input int j);
        return (n == 2) ? acc2[i][j] : acc4[i][j];
    endfunction

    task automatic check_c(input int n, input string tag);
        int s;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += matA[i][k] * matB[k][j];
                chk($sformatf("%s_C%0d%0d", tag, i, j), 64'(get_acc(n, i, j)), 64'(s & 16'hFFFF));
            end
        end
    endtask

    task automatic drive_wr(input int n, input logic en, input logic sel, input int addr, input logic [7:0] d);
        if (n == 2) begin
            if2.wr_en = en; if2.wr_sel = sel; if2.wr_addr = 2'(addr); if2.wr_data = d;
        end else begin
            if4.wr_en = en; if4.wr_sel = sel; if4.wr_addr = 4'(addr); if4.wr_data = d;
        end
    endtask

    task automatic drive_start(input int n, input logic v);
        if (n == 2) if2.start = v;
        else        if4.start = v;
    endtask

    task automatic write(input int n, input logic sel, input int r, input int c, input int d);
        drive_wr(n, 1'b1, sel, r*n + c, 8'(d));
        if (sel) matB[r][c] = d; else matA[r][c] = d;
        @(negedge clk);
        drive_wr(n, 1'b0, 1'b0, 0, 8'd0);
    endtask

    task automatic run(input int n, input bit use_tbl, input bit poke, input bit same_wr, input string tag);
        int   len;
        int   dones;
        rec_t e;
        rec_t z;
        len = 3 * n; dones = 0; z = '{default: '0};
        drive_start(n, 1'b1);
        if (same_wr) begin
            drive_wr(n, 1'b1, 1'b1, 3, 8'd2);
            matB[1][1] = 2;
        end
        for (int c = 0; c < len; c++) sb.push_back(use_tbl ? tbl33[c] : exp_rec(n, c));
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            drive_start(n, 1'b0);
            drive_wr(n, 1'b0, 1'b0, 0, 8'd0);
            e = sb.pop_front();
            cmp_rec(n, e, $sformatf("%s_c%0d", tag, c));
            if (cur_done(n)) dones++;
            if (c == len - 1) check_c(n, tag);
            if (poke && c == 2) begin
                drive_wr(n, 1'b1, 1'b0, 0, 8'd9);
                drive_start(n, 1'b1);
            end
            if (poke && c == len - 1) drive_start(n, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_start(n, 1'b0);
            if (cur_done(n)) dones++;
            if (k == 0) cmp_rec(n, z, {tag, "_idle"});
        end
        chk({tag, "_done_cnt"}, 64'(dones), 64'd1);
    endtask

    initial begin
        rec_t z;
        int   dcnt;
        checks = 0; failures = 0;
        z = '{default: '0};
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) begin matA[i][j] = 0; matB[i][j] = 0; end

        tbl33[0] = '{64'h0,    64'h0,    1'b1, 1'b1, 1'b0};
        tbl33[1] = '{64'h0001, 64'h0005, 1'b0, 1'b1, 1'b0};
        tbl33[2] = '{64'h0302, 64'h0607, 1'b0, 1'b1, 1'b0};
        tbl33[3] = '{64'h0400, 64'h0800, 1'b0, 1'b1, 1'b0};
        tbl33[4] = '{64'h0,    64'h0,    1'b0, 1'b1, 1'b0};
        tbl33[5] = '{64'h0,    64'h0,    1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        drive_wr(2, 1'b0, 1'b0, 0, 8'd0); drive_start(2, 1'b0);
        drive_wr(4, 1'b0, 1'b0, 0, 8'd0); drive_start(4, 1'b0);
        #3;
        cmp_rec(2, z, "reset2");
        cmp_rec(4, z, "reset4");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) write(2, 1'b0, k / 2, k % 2, k + 1);
        for (int k = 0; k < 4; k++) write(2, 1'b1, k / 2, k % 2, k + 5);

        run(2, 1'b1, 1'b0, 1'b0, "basic");
        run(2, 1'b1, 1'b0, 1'b0, "repeat");
        run(2, 1'b1, 1'b1, 1'b0, "busy_poke");
        run(2, 1'b1, 1'b0, 1'b0, "after_poke");
        run(2, 1'b0, 1'b0, 1'b1, "wr_start");

        // Abort a run with an asynchronous reset while FEED t=1 is on the outputs.
        drive_start(2, 1'b1);
        @(negedge clk); drive_start(2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 cmp_rec(2, z, "rst_midfeed");
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) begin matA[i][j] = 0; matB[i][j] = 0; end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if2.done) dcnt++;
        end
        chk("rst_no_done", 64'(dcnt), 64'd0);
        run(2, 1'b0, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            write(4, 1'b0, i, j, int'($urandom_range(0, 255)));
            write(4, 1'b1, i, j, int'($urandom_range(0, 255)));
        end
        run(4, 1'b0, 1'b0, 1'b0, "n4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand bit width matching the processing elements.
REQ-002 SHALL have parameter N, default 2, array dimension; legal range 2..8.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have wr_en  input  1  operand buffer write strobe.
REQ-006 SHALL have wr_sel  input  1  buffer select: 0 = matrix A, 1 = matrix B.
REQ-007 SHALL have wr_addr  input  max(1,clog2(N*N))  element index = row*N + col.
REQ-008 SHALL have wr_data  input  WIDTH  element value, unsigned.
REQ-009 SHALL have start  input  1  single-cycle request to run one multiply.
REQ-010 SHALL have a_feed  output  N*WIDTH  row operands for the left PE column; slice i = a_feed[i*WIDTH +: WIDTH] drives row i.
REQ-011 SHALL have b_feed  output  N*WIDTH  column operands for the top PE row; slice j drives column j.
REQ-012 SHALL have pe_clear  output  1  accumulator clear for every PE.
REQ-013 SHALL have busy  output  1  high in CLEAR and FEED states.
REQ-014 SHALL have done  output  1  one-cycle pulse; PE results are final while high.

Function
REQ-015 SHALL hold two N*N x WIDTH register buffers (A, B); an edge with wr_en=1 and busy=0 writes wr_data to the buffer selected by wr_sel at wr_addr.
REQ-016 SHALL ignore wr_en while busy=1; buffer contents SHALL be unchanged.
REQ-017 SHALL ignore out-of-range wr_addr (>= N*N); no buffer change.
REQ-018 SHALL implement FSM IDLE -> CLEAR -> FEED -> DONE -> IDLE, with all outputs registered.
REQ-019 IDLE: start=1 at an edge SHALL move to CLEAR; otherwise stay.
REQ-020 CLEAR lasts exactly 1 cycle: pe_clear=1, a_feed=b_feed=0.
REQ-021 FEED lasts exactly 3N-2 cycles, counted t = 0..3N-3; pe_clear=0.
REQ-022 In FEED cycle t, row slice i SHALL equal A[i][t-i] if 0 <= t-i < N, else 0.
REQ-023 In FEED cycle t, column slice j SHALL equal B[t-j][j] if 0 <= t-j < N, else 0.
REQ-024 DONE lasts 1 cycle with done=1 and a_feed=b_feed=0, then the FSM returns to IDLE.
REQ-025 Latency: done SHALL be high exactly 3N cycles after the edge that sampled start, with the CLEAR cycle counted as cycle 1.
REQ-026 SHALL ignore start while busy=1 or in DONE.
REQ-027 A write and start on the same IDLE edge SHALL both take effect; the new value SHALL be used by the run.
REQ-028 Buffers SHALL retain contents across runs; back-to-back runs without rewrites SHALL produce identical feed sequences.
REQ-029 SHALL perform no arithmetic on operands; operands pass unmodified, and zero padding is all-zero WIDTH bits.
REQ-030 In IDLE, outputs SHALL be a_feed=b_feed=0 and pe_clear=busy=done=0.

Reset
REQ-031 While rst=1, the FSM SHALL go to IDLE, the counter to 0, all outputs to 0, and both buffers to all zeros, without waiting for a clock edge.
REQ-032 Reset mid-FEED SHALL abort the run with no done pulse; the first start after reset SHALL begin a normal run.

Verification
REQ-033 N=2; write A=[[1,2],[3,4]], B=[[5,6],[7,8]]; pulse start -> CLEAR with pe_clear=1, then (a row0,row1 / b col0,col1) per FEED cycle: t0 1,0/5,0; t1 2,3/7,6; t2 0,4/0,8; t3 0,0/0,0; then done=1.
REQ-034 Same data driving a 2x2 PE array -> at done, C = [[19,22],[43,50]]; second start without rewrites -> identical sequence and results.
REQ-035 wr_en with A[0][0]=9 while busy -> current and next run still feed A[0][0]=1; start while busy -> no extra run, single done pulse.
REQ-036 Assert rst during FEED t=1 -> all outputs 0 immediately, no done pulse, buffers read back 0 on the next run (all-zero feeds).
REQ-037 wr_en writing B[1][1]=2 on the same edge as start -> the run feeds 2 at t2 in col1.
REQ-038 N=4 random unsigned operands -> feed matches REQ-022/023 every cycle, done exactly 12 cycles after start, array result equals the reference product mod 2^(2*WIDTH).
